// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state codes, bit-counter
// select codes and the Moore output decode of the receive FSM.
package uart_rx_pkg;

  localparam int K_WIDTH_DEF = 19;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;

  localparam logic [1:0] SEL_CLEAR = 2'b00;
  localparam logic [1:0] SEL_HOLD  = 2'b10;
  localparam logic [1:0] SEL_INC   = 2'b11;

  typedef struct packed {
    logic start;
    logic doit;
  } rx_moore_t;

  // Encoding 11 decodes like IDLE so nothing runs while it recovers.
  function automatic rx_moore_t moore_dec(input logic [1:0] st);
    rx_moore_t m;
    m = '{start: 1'b0, doit: 1'b0};
    case (st)
      START:   m = '{start: 1'b1, doit: 1'b1};
      DATA:    m = '{start: 1'b0, doit: 1'b1};
      default: m = '{start: 1'b0, doit: 1'b0};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rx_bit_time_counter.sv
// Bit-time counter: emits btu once per half bit in START and once per full
// bit in DATA, with the divisor clamped to at least 2.
module rx_bit_time_counter #(
  parameter int K_WIDTH = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               doit,
  input  logic               start,
  input  logic [K_WIDTH-1:0] k,
  output logic               btu
);

  logic [K_WIDTH-1:0] cnt, keff, target;

  assign keff   = (k < K_WIDTH'(2)) ? K_WIDTH'(2) : k;
  assign target = start ? (keff >> 1) : keff;
  // keff >= 2 keeps target >= 1, so target-1 never wraps.
  assign btu    = doit && (cnt == target - K_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst || !doit)  cnt <= '0;
    else if (btu)      cnt <= '0;
    else               cnt <= cnt + K_WIDTH'(1);
  end

endmodule

// File: rtl/rx_ctrl_fsm.sv
// UART receive control: RX pin synchronizer, start-bit detect with glitch
// reject, mid-bit strobe timing and bit-counter sequencing.
module rx_ctrl_fsm
  import uart_rx_pkg::*;
#(
  parameter int K_WIDTH     = K_WIDTH_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  input  logic [K_WIDTH-1:0] k,
  input  logic               done,
  output logic [1:0]         sel,
  output logic               shift_en,
  output logic               rx_s,
  output logic               rx_busy,
  output logic               rx_done
);

  logic [SYNC_STAGES-1:0] sync_pipe;
  logic [1:0]             state, state_nxt;
  rx_moore_t              mo;
  logic                   btu;

  // Flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_pipe <= '1;
    else     sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], rx};
  end

  assign rx_s = sync_pipe[SYNC_STAGES-1];
  assign mo   = moore_dec(state);

  rx_bit_time_counter #(.K_WIDTH(K_WIDTH)) u_btc (
    .clk   (clk),
    .rst   (rst),
    .doit  (mo.doit),
    .start (mo.start),
    .k     (k),
    .btu   (btu)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START: begin
        if (rx_s)     state_nxt = IDLE;
        else if (btu) state_nxt = DATA;
      end
      DATA:    if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign sel      = !mo.doit ? SEL_CLEAR : (btu ? SEL_INC : SEL_HOLD);
  assign shift_en = btu;
  assign rx_busy  = mo.doit;
  assign rx_done  = (state == DATA) && done;

endmodule

// File: tb/tb_rx_ctrl_fsm.sv
// Directed bench for rx_ctrl_fsm with a behavioural 4-bit Rx bit counter and
// a cycle-stamped event log of strobes, START entries and rx_done pulses.
module tb_rx_ctrl_fsm;

  localparam int KW = 19;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx  = 1'b0;
  logic [KW-1:0] k   = KW'(16);
  logic          done;
  logic [1:0]    sel;
  logic          shift_en, rx_s, rx_busy, rx_done;

  logic [3:0] bc = 4'd0;
  logic [3:0] num_bits = 4'd10;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic busy_prev = 1'b0;

  int   se_q[$];
  int   start_q[$];
  int   fall_q[$];
  int   done_q[$];
  logic bits_q[$];

  rx_ctrl_fsm #(.K_WIDTH(KW), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .k        (k),
    .done     (done),
    .sel      (sel),
    .shift_en (shift_en),
    .rx_s     (rx_s),
    .rx_busy  (rx_busy),
    .rx_done  (rx_done)
  );

  always #5 clk = ~clk;

  // Downstream bit counter: 0x clears, 10 holds, 11 increments.
  always @(posedge clk) begin
    if (!sel[1])     bc <= 4'd0;
    else if (sel[0]) bc <= bc + 4'd1;
  end
  assign done = (bc == num_bits);

  // Event log, stamped with the cycle number of each falling edge.
  initial forever begin
    @(negedge clk);
    cyc = cyc + 1;
    if (shift_en) begin se_q.push_back(cyc); bits_q.push_back(rx_s); end
    if (rx_busy && !busy_prev) start_q.push_back(cyc);
    if (!rx_busy && busy_prev) fall_q.push_back(cyc);
    if (rx_done) done_q.push_back(cyc);
    busy_prev = rx_busy;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clear_log();
    se_q.delete(); start_q.delete(); fall_q.delete(); done_q.delete(); bits_q.delete();
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  function automatic logic [7:0] byte_of(input int base, input int n);
    logic [7:0] b = 8'h00;
    for (int i = 0; i < n; i++)
      if (base + i < bits_q.size()) b[i] = bits_q[base + i];
    return b;
  endfunction

  function automatic int bad_gaps(input int gap);
    int bad = 0;
    for (int i = 1; i < se_q.size(); i++)
      if (se_q[i] - se_q[i-1] != gap) bad++;
    return bad;
  endfunction

  // Start bit, nd data bits LSB first, one stop bit; each held bt cycles.
  task automatic send_frame(input logic [7:0] data, input int nd, input int bt, output int fall);
    fall = cyc;
    rx = 1'b0; tick(bt);
    for (int i = 0; i < nd; i++) begin rx = data[i]; tick(bt); end
    rx = 1'b1; tick(bt);
  endtask

  task automatic test_reset();
    rst = 1'b1; rx = 1'b0;
    tick(3);
    checks++; if (sel !== 2'b00)   begin errors++; $display("FAIL reset_sel: got %b want 00", sel); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
    checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
    checks++; if (rx_done !== 1'b0) begin errors++; $display("FAIL reset_rx_done: got %b want 0", rx_done); end
    checks++; if (rx_s !== 1'b1)    begin errors++; $display("FAIL reset_rx_s: got %b want 1", rx_s); end
    rx = 1'b1; tick(2);
    rst = 1'b0; tick(4);
  endtask

  task automatic test_8n1();
    int f;
    k = KW'(16); num_bits = 4'd10; clear_log();
    send_frame(8'h55, 8, 16, f);
    tick(20);
    checks++; if (qget(start_q, 0) !== f + 3) begin errors++; $display("FAIL 8n1_start_latency: got %0d want %0d", qget(start_q, 0), f + 3); end
    checks++; if (se_q.size() !== 10) begin errors++; $display("FAIL 8n1_strobes: got %0d want 10", se_q.size()); end
    // First strobe lands in the 8th START cycle (cnt reaches target-1).
    checks++; if (qget(se_q, 0) !== qget(start_q, 0) + 7) begin errors++; $display("FAIL 8n1_first_strobe: got %0d want %0d", qget(se_q, 0), qget(start_q, 0) + 7); end
    checks++; if (bad_gaps(16) !== 0) begin errors++; $display("FAIL 8n1_spacing: got %0d bad gaps want 0", bad_gaps(16)); end
    checks++; if (byte_of(1, 8) !== 8'h55) begin errors++; $display("FAIL 8n1_data: got %h want 55", byte_of(1, 8)); end
    checks++; if (byte_of(0, 1) !== 8'h00 || byte_of(9, 1) !== 8'h01) begin errors++; $display("FAIL 8n1_start_stop: got %h/%h want 00/01", byte_of(0, 1), byte_of(9, 1)); end
    checks++; if (done_q.size() !== 1 || qget(done_q, 0) !== qget(se_q, 9) + 1) begin errors++; $display("FAIL 8n1_rx_done: got %0d pulses at %0d want 1 at %0d", done_q.size(), qget(done_q, 0), qget(se_q, 9) + 1); end
    checks++; if (qget(fall_q, 0) !== qget(done_q, 0) + 1) begin errors++; $display("FAIL 8n1_busy_fall: got %0d want %0d", qget(fall_q, 0), qget(done_q, 0) + 1); end
  endtask

  task automatic test_glitch();
    int f;
    k = KW'(16); clear_log();
    f = cyc;
    rx = 1'b0; tick(3);
    rx = 1'b1; tick(30);
    checks++; if (qget(start_q, 0) !== f + 3 || start_q.size() !== 1) begin errors++; $display("FAIL glitch_start: got %0d entries first %0d want 1 at %0d", start_q.size(), qget(start_q, 0), f + 3); end
    checks++; if (qget(fall_q, 0) - qget(start_q, 0) !== 3) begin errors++; $display("FAIL glitch_start_len: got %0d want 3", qget(fall_q, 0) - qget(start_q, 0)); end
    checks++; if (se_q.size() !== 0 || done_q.size() !== 0) begin errors++; $display("FAIL glitch_strobes: got %0d/%0d want 0/0", se_q.size(), done_q.size()); end
    checks++; if (sel !== 2'b00 || rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got sel %b busy %b want 00 0", sel, rx_busy); end
  endtask

  task automatic test_reset_mid();
    int f, t;
    k = KW'(16); num_bits = 4'd10; clear_log();
    t = 0;
    fork
      send_frame(8'hFC, 8, 16, f);
      begin
        while (se_q.size() < 4 && t < 200) begin tick(1); t++; end
        rst = 1'b1; tick(1);
        checks++; if (rx_busy !== 1'b0 || sel !== 2'b00) begin errors++; $display("FAIL midrst_idle: got busy %b sel %b want 0 00", rx_busy, sel); end
        rst = 1'b0;
      end
    join
    tick(20);
    checks++; if (t >= 200) begin errors++; $display("FAIL midrst_timeout: got %0d cycles want < 200", t); end
    checks++; if (done_q.size() !== 0 || se_q.size() !== 4) begin errors++; $display("FAIL midrst_abort: got done %0d strobes %0d want 0 4", done_q.size(), se_q.size()); end
    clear_log();
    send_frame(8'hA5, 8, 16, f);
    tick(20);
    checks++; if (byte_of(1, 8) !== 8'hA5 || done_q.size() !== 1) begin errors++; $display("FAIL midrst_next: got %h done %0d want a5 1", byte_of(1, 8), done_q.size()); end
  endtask

  task automatic test_clamp();
    int f;
    num_bits = 4'd10;
    for (int kk = 0; kk < 2; kk++) begin
      k = KW'(kk); clear_log();
      send_frame(8'h3C, 8, 2, f);
      tick(10);
      checks++; if (se_q.size() !== 10) begin errors++; $display("FAIL clamp%0d_strobes: got %0d want 10", kk, se_q.size()); end
      checks++; if (qget(se_q, 0) !== qget(start_q, 0)) begin errors++; $display("FAIL clamp%0d_first: got %0d want %0d", kk, qget(se_q, 0), qget(start_q, 0)); end
      checks++; if (bad_gaps(2) !== 0) begin errors++; $display("FAIL clamp%0d_spacing: got %0d bad gaps want 0", kk, bad_gaps(2)); end
      checks++; if (byte_of(1, 8) !== 8'h3C || done_q.size() !== 1) begin errors++; $display("FAIL clamp%0d_data: got %h done %0d want 3c 1", kk, byte_of(1, 8), done_q.size()); end
    end
  endtask

  task automatic test_back_to_back();
    int f1, f2;
    k = KW'(16); num_bits = 4'd9; clear_log();
    send_frame(8'h2A, 7, 16, f1);
    send_frame(8'h55, 7, 16, f2);
    tick(30);
    checks++; if (done_q.size() !== 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_q.size()); end
    checks++; if (se_q.size() !== 18) begin errors++; $display("FAIL b2b_strobes: got %0d want 18", se_q.size()); end
    checks++; if (qget(start_q, 1) !== f2 + 3) begin errors++; $display("FAIL b2b_second_start: got %0d want %0d", qget(start_q, 1), f2 + 3); end
    checks++; if (byte_of(1, 7) !== 8'h2A || byte_of(10, 7) !== 8'h55) begin errors++; $display("FAIL b2b_data: got %h/%h want 2a/55", byte_of(1, 7), byte_of(10, 7)); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_8n1();
    test_glitch();
    test_reset_mid();
    test_clamp();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
